hexled_share_ctrl: RTL and testbench

// - Shares the single 8-digit HexLED display write port (32-bit data, 1-cycle write strobe) between NREQ requesters.
// - Round-robin arbitration; each winner's value is written once, then held on the display for a dwell period before re-arbitration.
// - Sits between client blocks (counters, game-state, debug) and the HexLED instance; oWR/oDATA connect directly to its iWR/iDATA.

---
 rtl/hexled_share_ctrl_pkg.sv | 17 +
 rtl/hexled_share_ctrl_if.sv | 24 ++
 rtl/hexled_share_ctrl_rr_pick.sv | 28 ++
 rtl/hexled_share_ctrl.sv | 119 +++++++++++
 tb/tb_hexled_share_ctrl.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/hexled_share_ctrl_pkg.sv
// Shared types and helpers for the HexLED display-sharing controller.
//   state_t    : controller FSM states
//   HEX_DATA_W : HexLED data word width
//   onehot()   : index -> one-hot vector (up to 8 requesters)
package hexled_pkg;

  typedef enum logic [1:0] {IDLE, WRITE, DWELL} state_t;

  localparam int HEX_DATA_W = 32;
  localparam int MAX_REQ    = 8;

  function automatic logic [MAX_REQ-1:0] onehot(input logic [2:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/hexled_share_ctrl_if.sv
// Requester/display bus of the HexLED sharing controller.
//   iREQ  : per-requester request level
//   iDATA : requester i's word in [i*DATA_W +: DATA_W]
//   oACK  : one-hot pulse, word written this cycle
//   oGNT  : one-hot current display owner
//   oBUSY : controller not idle
//   oWR   : write strobe to HexLED
//   oDATA : data to HexLED, holds last written word
// master = client side, slave = controller side.
interface hexled_share_ctrl_if #(
  parameter int NREQ   = 4,
  parameter int DATA_W = 32
);
  logic [NREQ-1:0]        iREQ;
  logic [NREQ*DATA_W-1:0] iDATA;
  logic [NREQ-1:0]        oACK;
  logic [NREQ-1:0]        oGNT;
  logic                   oBUSY;
  logic                   oWR;
  logic [DATA_W-1:0]      oDATA;

  modport master (output iREQ, iDATA, input oACK, oGNT, oBUSY, oWR, oDATA);
  modport slave  (input iREQ, iDATA, output oACK, oGNT, oBUSY, oWR, oDATA);
endinterface

// File: rtl/hexled_share_ctrl_rr_pick.sv
// Combinational rotating-priority picker.
//   req   : request vector
//   ptr   : index with highest priority this round
//   valid : some request is set
//   idx   : first set request searching ptr, ptr+1, ... with wrap
module rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic            valid,
  output logic [PW-1:0]   idx
);

  // Walk from the farthest position back to ptr so the closest hit wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % NREQ]) begin
        valid = 1'b1;
        idx   = PW'((int'(ptr) + k) % NREQ);
      end
    end
  end

endmodule

// File: rtl/hexled_share_ctrl.sv
// Shares the single HexLED write port among NREQ requesters. Round-robin
// grant, one write per grant, then the value is held for DWELL_CYCLES
// before the next arbitration.
//   iCLOCK : clock, rising edge
//   iRESET : synchronous active-high reset
//   bus    : request/display bus (slave side)
module hexled_share_ctrl
  import hexled_pkg::*;
#(
  parameter int NREQ         = 4,
  parameter int DATA_W       = HEX_DATA_W,
  parameter int DWELL_CYCLES = 50000000
) (
  input logic                 iCLOCK,
  input logic                 iRESET,
  hexled_share_ctrl_if.slave  bus
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(DWELL_CYCLES + 1);

  state_t            state, nstate;
  logic [PW-1:0]     ptr, win, nxt_ptr, nxt_win;
  logic [CW-1:0]     cnt, nxt_cnt;
  logic              wr_q, busy_q, nxt_wr, nxt_busy;
  logic [NREQ-1:0]   ack_q, gnt_q, nxt_ack, nxt_gnt;
  logic [DATA_W-1:0] data_q, nxt_data;

  logic              pick_vld;
  logic [PW-1:0]     pick_idx;
  logic [7:0]        pick_oh;

  rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req   (bus.iREQ),
    .ptr   (ptr),
    .valid (pick_vld),
    .idx   (pick_idx)
  );

  assign pick_oh = onehot(3'(pick_idx));

  // State and all registered outputs.
  always_ff @(posedge iCLOCK) begin
    if (iRESET) begin
      state  <= IDLE;
      ptr    <= '0;
      win    <= '0;
      cnt    <= '0;
      wr_q   <= 1'b0;
      busy_q <= 1'b0;
      ack_q  <= '0;
      gnt_q  <= '0;
      data_q <= '0;
    end else begin
      state  <= nstate;
      ptr    <= nxt_ptr;
      win    <= nxt_win;
      cnt    <= nxt_cnt;
      wr_q   <= nxt_wr;
      busy_q <= nxt_busy;
      ack_q  <= nxt_ack;
      gnt_q  <= nxt_gnt;
      data_q <= nxt_data;
    end
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (pick_vld) nstate = WRITE;
      WRITE:   nstate = DWELL;
      DWELL:   if (cnt == '0) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    nxt_ptr  = ptr;
    nxt_win  = win;
    nxt_cnt  = cnt;
    nxt_wr   = 1'b0;
    nxt_ack  = '0;
    nxt_busy = busy_q;
    nxt_gnt  = gnt_q;
    nxt_data = data_q;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          // Data is captured only here; later iDATA changes are ignored.
          nxt_win  = pick_idx;
          nxt_data = bus.iDATA[int'(pick_idx)*DATA_W +: DATA_W];
          nxt_wr   = 1'b1;
          nxt_ack  = pick_oh[NREQ-1:0];
          nxt_gnt  = pick_oh[NREQ-1:0];
          nxt_busy = 1'b1;
        end
      end
      WRITE: nxt_cnt = CW'(DWELL_CYCLES - 1);
      DWELL: begin
        if (cnt == '0) begin
          nxt_gnt  = '0;
          nxt_busy = 1'b0;
          // Winner gets lowest priority next round.
          nxt_ptr  = (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
        end else begin
          nxt_cnt = cnt - 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign bus.oWR   = wr_q;
  assign bus.oACK  = ack_q;
  assign bus.oGNT  = gnt_q;
  assign bus.oBUSY = busy_q;
  assign bus.oDATA = data_q;

endmodule

// File: tb/tb_hexled_share_ctrl.sv
module tb_hexled_share_ctrl;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int D  = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hexled_share_ctrl_if #(.NREQ(N), .DATA_W(DW)) bus ();

  hexled_share_ctrl #(.NREQ(N), .DATA_W(DW), .DWELL_CYCLES(D)) dut (
    .iCLOCK (clk),
    .iRESET (rst),
    .bus    (bus.slave)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: owner index (-1 = none), cycles of ownership left,
  // next priority pointer and the word on the display.
  int          m_own  = -1;
  int          m_left = 0;
  int          m_ptr  = 0;
  logic [DW-1:0] m_data = '0;
  logic        m_wr   = 1'b0;
  logic [N-1:0] m_ack = '0;
  logic [N-1:0] drop_mask = '1;
  int          wr_cyc[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    m_wr  = 1'b0;
    m_ack = '0;
    if (rst) begin
      m_own = -1; m_left = 0; m_ptr = 0; m_data = '0;
    end else if (m_own < 0) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (bus.iREQ[c]) begin
          m_own  = c;
          m_left = D + 1;          // WRITE cycle plus D dwell cycles
          m_data = bus.iDATA[c*DW +: DW];
          m_wr   = 1'b1;
          m_ack  = N'(1) << c;
          break;
        end
      end
    end else begin
      m_left--;
      if (m_left == 0) begin
        m_ptr = (m_own + 1) % N;
        m_own = -1;
      end
    end
    if (m_wr) wr_cyc.push_back(cyc);
    #1;
    chk("wr",   64'(bus.oWR),   64'(m_wr));
    chk("ack",  64'(bus.oACK),  64'(m_ack));
    chk("gnt",  64'(bus.oGNT),  (m_own < 0) ? 64'd0 : (64'd1 << m_own));
    chk("busy", 64'(bus.oBUSY), 64'(m_own >= 0));
    chk("data", 64'(bus.oDATA), 64'(m_data));
    bus.iREQ = bus.iREQ & ~(m_ack & drop_mask);
  endtask

  task automatic wait_ack(output logic [N-1:0] a);
    a = '0;
    for (int n = 0; n < 60; n++) begin
      step();
      if (m_ack != '0) begin
        a = m_ack;
        return;
      end
    end
    chk("ack_timeout", 64'd0, 64'd1);
  endtask

  task automatic go_idle();
    for (int n = 0; n < 20 && m_own >= 0; n++) step();
  endtask

  logic [N-1:0] a;

  initial begin
    rst = 1'b1;
    bus.iREQ  = '1;
    bus.iDATA = '0;
    for (int i = 0; i < N; i++) bus.iDATA[i*DW +: DW] = 32'h1000_0000 + i;

    // Reset held with all requesting: nothing written.
    step(); step();
    chk("rst_wr",  64'(bus.oWR),  64'd0);
    chk("rst_gnt", 64'(bus.oGNT), 64'd0);

    // Round-robin from ptr=0, every requester drops on its ack.
    rst = 1'b0;
    wr_cyc.delete();
    for (int k = 0; k < N; k++) begin
      wait_ack(a);
      chk($sformatf("rr_order%0d", k), 64'(a), 64'd1 << k);
    end
    for (int k = 1; k < wr_cyc.size(); k++)
      chk("rr_spacing", 64'(wr_cyc[k] - wr_cyc[k-1]), 64'(D + 2));
    go_idle();

    // Single request; data changed during WRITE/DWELL must not show.
    bus.iREQ = 4'b0100;
    bus.iDATA[2*DW +: DW] = 32'hDEAD_BEEF;
    wait_ack(a);
    chk("single_ack",  64'(a),         64'h4);
    chk("single_data", 64'(bus.oDATA), 64'hDEAD_BEEF);
    bus.iDATA[2*DW +: DW] = 32'h1234_5678;
    for (int k = 0; k < D; k++) begin
      step();
      chk("single_hold", 64'(bus.oGNT), 64'h4);
    end
    step();
    chk("single_release", 64'(bus.oGNT), 64'h0);
    chk("single_keep", 64'(bus.oDATA), 64'hDEAD_BEEF);
    go_idle();

    // Fairness: req1 never drops; req3 arrives during req1's dwell.
    drop_mask = 4'b1101;
    bus.iREQ  = 4'b0010;
    wait_ack(a);
    chk("fair_first", 64'(a), 64'h2);
    step(); step();
    bus.iREQ[3] = 1'b1;
    wait_ack(a);
    chk("fair_req3", 64'(a), 64'h8);
    wait_ack(a);
    chk("fair_req1", 64'(a), 64'h2);
    drop_mask = '1;
    bus.iREQ  = '0;
    go_idle();
    step();

    // Reset in the 2nd dwell cycle; pointer must restart at 0.
    bus.iREQ = 4'b0001;
    wait_ack(a);
    step(); step();
    rst = 1'b1;
    step();
    chk("mid_rst_gnt",  64'(bus.oGNT),  64'h0);
    chk("mid_rst_busy", 64'(bus.oBUSY), 64'h0);
    chk("mid_rst_data", 64'(bus.oDATA), 64'h0);
    chk("mid_rst_wr",   64'(bus.oWR),   64'h0);
    rst = 1'b0;
    bus.iREQ = '1;
    wait_ack(a);
    chk("mid_rst_ptr", 64'(a), 64'h1);
    go_idle();

    // Random traffic; ack'd requesters usually drop, sometimes keep.
    drop_mask = '0;
    for (int n = 0; n < 2500; n++) begin
      rst = ($urandom % 150) == 0;
      for (int i = 0; i < N; i++) begin
        bus.iDATA[i*DW +: DW] = $urandom;
      end
      step();
      for (int i = 0; i < N; i++) begin
        if (m_ack[i]) begin
          if ($urandom % 4 != 0) bus.iREQ[i] = 1'b0;
        end else if (!bus.iREQ[i]) begin
          if ($urandom % 4 == 0) bus.iREQ[i] = 1'b1;
        end else if ($urandom % 50 == 0) begin
          bus.iREQ[i] = 1'b0;
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
